// File: rtl/sbox_layer_serial.sv
// Serialized PRESENT substitution layer: one shared 4-bit S-box walks the 16
// nibbles of a 64-bit state, LSB nibble first, one nibble per clock.
module sbox_layer_serial (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] state_in,
   output logic [63:0] state_out,
   output logic        busy,
   output logic        done
);

   localparam int unsigned STATE_W = 64;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fsm_t;

   fsm_t               r_fsm;
   logic [CNT_W-1:0]   r_cnt;
   logic [STATE_W-1:0] r_state;
   logic               r_busy;
   logic               r_done;

   logic [NIB_W-1:0]   w_nib_in;
   logic [NIB_W-1:0]   w_nib_out;

   assign w_nib_in = r_state[{r_cnt, 2'b00} +: NIB_W];

   // The single shared S-box
   always_comb begin
      w_nib_out = 4'hC;
      case (w_nib_in)
         4'h0: w_nib_out = 4'hC;
         4'h1: w_nib_out = 4'h5;
         4'h2: w_nib_out = 4'h6;
         4'h3: w_nib_out = 4'hB;
         4'h4: w_nib_out = 4'h9;
         4'h5: w_nib_out = 4'h0;
         4'h6: w_nib_out = 4'hA;
         4'h7: w_nib_out = 4'hD;
         4'h8: w_nib_out = 4'h3;
         4'h9: w_nib_out = 4'hE;
         4'hA: w_nib_out = 4'hF;
         4'hB: w_nib_out = 4'h8;
         4'hC: w_nib_out = 4'h4;
         4'hD: w_nib_out = 4'h7;
         4'hE: w_nib_out = 4'h1;
         4'hF: w_nib_out = 4'h2;
         default: w_nib_out = 4'hC;
      endcase
   end

   // busy/done are registered alongside the state so they track it exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm   <= S_IDLE;
         r_cnt   <= '0;
         r_state <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (start) begin
                  r_state <= state_in;
                  r_cnt   <= '0;
                  r_fsm   <= S_RUN;
                  r_busy  <= 1'b1;
               end
            end
            S_RUN: begin
               r_state[{r_cnt, 2'b00} +: NIB_W] <= w_nib_out;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(15)) begin
                  r_fsm  <= S_DONE;
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            S_DONE: begin
               r_fsm  <= S_IDLE;
               r_done <= 1'b0;
            end
            default: begin
               r_fsm  <= S_IDLE;
               r_busy <= 1'b0;
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign state_out = r_state;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_sbox_layer_serial.sv
// Scoreboard bench for sbox_layer_serial: expected results are queued at start
// and compared whenever done pulses; partial results are checked during RUN.
module tb_sbox_layer_serial;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] state_in;
   logic [63:0] state_out;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   logic [63:0] exp_q[$];

   sbox_layer_serial dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .state_in  (state_in),
      .state_out (state_out),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] sbox_ref(input logic [3:0] v);
      case (v)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   // State after k nibbles (LSB first) have been substituted
   function automatic logic [63:0] partial_ref(input logic [63:0] d, input int k);
      logic [63:0] r;
      r = d;
      for (int i = 0; i < k; i++) r[4*i +: 4] = sbox_ref(d[4*i +: 4]);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pulse consumes one queued expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_done++;
         if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
         else check("result", state_out, exp_q.pop_front());
      end
   end

   // One full operation with per-cycle partial-state and timing checks
   task automatic run_op(input logic [63:0] d);
      int lat;
      int busy_c;
      lat = 0;
      busy_c = 0;
      @(posedge clk); #1;
      start = 1'b1;
      state_in = d;
      exp_q.push_back(partial_ref(d, 16));
      @(posedge clk); #1;
      start = 1'b0;
      state_in = ~d;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) begin
            busy_c++;
            check("partial", state_out, partial_ref(d, lat - 1));
         end
         if (done) break;
      end
      check("done_latency", 64'(lat), 64'd17);
      check("busy_cycles", 64'(busy_c), 64'd16);
      @(negedge clk);
      check("done_pulse_width", 64'(done), 64'd0);
      check("hold_after_done", state_out, partial_ref(d, 16));
   endtask

   initial begin
      int base;
      int cyc;
      logic [63:0] rv;
      rst = 1'b1;
      start = 1'b0;
      state_in = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_state_out", state_out, 64'h0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic vectors
      run_op(64'h0);
      check("zero_vec", state_out, 64'hCCCC_CCCC_CCCC_CCCC);
      run_op(64'h0123_4567_89AB_CDEF);
      check("known_vec", state_out, 64'hC56B_90AD_3EF8_4712);

      // Start held high with all-ones input: three back-to-back operations
      base = n_done;
      @(posedge clk); #1;
      start = 1'b1;
      state_in = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) exp_q.push_back(64'h2222_2222_2222_2222);
      cyc = 0;
      while (n_done - base < 3 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            start = 1'b0;
            if (n_done - base < 3) start = 1'b1;
            @(negedge clk);
            cyc++;
            check("idle_after_done", 64'(busy), 64'd0);
            check("held_start_result_hold", state_out, 64'h2222_2222_2222_2222);
         end
      end
      start = 1'b0;
      repeat (30) @(negedge clk);
      check("held_start_done_count", 64'(n_done - base), 64'd3);

      // Start pulse and new input mid-RUN are ignored
      base = n_done;
      @(posedge clk); #1;
      start = 1'b1;
      state_in = 64'hDEAD_BEEF_0BAD_F00D;
      exp_q.push_back(partial_ref(64'hDEAD_BEEF_0BAD_F00D, 16));
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1;
      state_in = 64'h1111_2222_3333_4444;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (40) @(negedge clk);
      check("midrun_done_count", 64'(n_done - base), 64'd1);
      check("midrun_result", state_out, partial_ref(64'hDEAD_BEEF_0BAD_F00D, 16));

      // Reset during RUN aborts without a done pulse
      base = n_done;
      @(posedge clk); #1;
      start = 1'b1;
      state_in = 64'h0123_4567_89AB_CDEF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_abort_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_state_out", state_out, 64'h0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("abort_no_done", 64'(n_done - base), 64'd0);
      run_op(64'h0123_4567_89AB_CDEF);
      check("after_abort_vec", state_out, 64'hC56B_90AD_3EF8_4712);

      // Exhaustive nibble sweep
      for (int v = 0; v < 16; v++) begin
         rv = {16{4'(v)}};
         run_op(rv);
         check("sweep", state_out, {16{sbox_ref(4'(v))}});
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
